// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR port arbiter.
// Command codes line up with ddr_memory_controller.
package ddr_arb_pkg;

  localparam logic [3:0] CMD_NOP   = 4'd0;
  localparam logic [3:0] CMD_READ  = 4'd1;
  localparam logic [3:0] CMD_WRITE = 4'd2;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RD,
    DRAIN
  } arb_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ddr_port_arbiter_rr_select.sv
// Combinational winner picker: fixed priority or
// round robin starting just after the pointer.
module rr_select
  import ddr_arb_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int IDX_W  = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              mode,
  output logic [NUM_CH-1:0] win,
  output logic [IDX_W-1:0]  win_idx,
  output logic              any
);

  always_comb begin : pick
    int base;
    int c;
    win     = '0;
    win_idx = '0;
    any     = 1'b0;
    c       = 0;
    base    = mode ? (int'(ptr) + 1) % NUM_CH : 0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = (base + k) % NUM_CH;
      if (!any && req[c]) begin
        any     = 1'b1;
        win_idx = IDX_W'(c);
        win[c]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// N-channel request arbiter in front of the DDR controller,
// with read-data return routing and a sticky read timeout.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_CH     = 5,
  parameter int ADDR_W     = 25,
  parameter int DATA_W     = 256,
  parameter int CMD_W      = 4,
  parameter int RR_MODE    = 1,
  parameter int RD_TIMEOUT = 1023
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        req,
  input  logic [NUM_CH-1:0]        req_wr,
  input  logic [NUM_CH*ADDR_W-1:0] req_addr,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  input  logic                     init_done,
  input  logic                     cmd_busy,
  input  logic                     ddr_data_valid,
  input  logic [DATA_W-1:0]        ddr_rd_data,
  output logic [CMD_W-1:0]         cmd,
  output logic                     cmd_valid,
  output logic [ADDR_W-1:0]        ddr_address,
  output logic [DATA_W-1:0]        ddr_wr_data,
  output logic [NUM_CH-1:0]        grant,
  output logic [NUM_CH-1:0]        rd_valid,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     busy,
  output logic                     rd_timeout
);

  localparam int IDX_W = clog2(NUM_CH);
  localparam int CNT_W = clog2(RD_TIMEOUT + 1);

  arb_state_t state, state_d;

  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  owner;
  logic [IDX_W-1:0]  win_idx;
  logic [NUM_CH-1:0] win;
  logic              any;
  logic              wr_q;
  logic [CNT_W-1:0]  rd_cnt;

  logic take;
  logic issued;
  logic rd_hit;
  logic rd_expire;

  rr_select #(
    .NUM_CH(NUM_CH),
    .IDX_W (IDX_W)
  ) u_sel (
    .req    (req),
    .ptr    (ptr),
    .mode   (RR_MODE != 0),
    .win    (win),
    .win_idx(win_idx),
    .any    (any)
  );

  assign busy = (state != IDLE) || !init_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    take      = 1'b0;
    issued    = 1'b0;
    rd_hit    = 1'b0;
    rd_expire = 1'b0;
    unique case (state)
      IDLE: begin
        if (init_done && !cmd_busy && any) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cmd_busy) begin
          issued  = 1'b1;
          state_d = wr_q ? DRAIN : WAIT_RD;
        end
      end
      WAIT_RD: begin
        if (ddr_data_valid) begin
          rd_hit  = 1'b1;
          state_d = DRAIN;
        end else if (rd_cnt == CNT_W'(RD_TIMEOUT)) begin
          rd_expire = 1'b1;
          state_d   = DRAIN;
        end
      end
      DRAIN: begin
        if (!cmd_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= IDX_W'(NUM_CH - 1);
      owner       <= '0;
      wr_q        <= 1'b0;
      cmd         <= CMD_W'(CMD_NOP);
      cmd_valid   <= 1'b0;
      ddr_address <= '0;
      ddr_wr_data <= '0;
      grant       <= '0;
      rd_valid    <= '0;
      rd_data     <= '0;
      rd_timeout  <= 1'b0;
      rd_cnt      <= '0;
    end else begin
      grant    <= '0;
      rd_valid <= '0;
      if (take) begin
        ptr         <= win_idx;
        owner       <= win_idx;
        wr_q        <= req_wr[win_idx];
        cmd         <= req_wr[win_idx] ? CMD_W'(CMD_WRITE)
                                       : CMD_W'(CMD_READ);
        cmd_valid   <= 1'b1;
        ddr_address <= req_addr[win_idx*ADDR_W +: ADDR_W];
        ddr_wr_data <= req_wdata[win_idx*DATA_W +: DATA_W];
        grant       <= win;
      end
      if (issued) begin
        cmd_valid <= 1'b0;
        rd_cnt    <= '0;
      end
      // counter only advances while a read is outstanding
      if (state == WAIT_RD) rd_cnt <= rd_cnt + CNT_W'(1);
      if (rd_hit) begin
        rd_data         <= ddr_rd_data;
        rd_valid[owner] <= 1'b1;
      end
      if (rd_expire) rd_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Bench for ddr_port_arbiter: table vectors, corner
// sequences and a randomized run against a winner model.
module tb_ddr_port_arbiter;
  import ddr_arb_pkg::*;

  localparam int N  = 5;
  localparam int AW = 25;
  localparam int DW = 256;
  localparam int CW = 4;
  localparam int TO = 1023;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_b = '0;
  logic [N-1:0]    req_wr = '0;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            init_done = 1'b0;
  logic            cmd_busy;
  logic            ddr_data_valid;
  logic [DW-1:0]   rsp_data = '0;

  logic [CW-1:0] cmd, cmd_b;
  logic          cmd_valid, cmd_valid_b;
  logic [AW-1:0] ddr_address, ddr_address_b;
  logic [DW-1:0] ddr_wr_data, ddr_wr_data_b;
  logic [N-1:0]  grant, grant_b, rd_valid, rd_valid_b;
  logic [DW-1:0] rd_data, rd_data_b;
  logic          busy, busy_b, rd_timeout, rd_timeout_b;

  logic [AW-1:0] a_ch [N];
  logic [DW-1:0] d_ch [N];

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = a_ch[i];
      req_wdata[i*DW +: DW] = d_ch[i];
    end
  end

  ddr_port_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .CMD_W(CW),
    .RR_MODE(1), .RD_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .init_done(init_done), .cmd_busy(cmd_busy),
    .ddr_data_valid(ddr_data_valid), .ddr_rd_data(rsp_data),
    .cmd(cmd), .cmd_valid(cmd_valid), .ddr_address(ddr_address),
    .ddr_wr_data(ddr_wr_data), .grant(grant), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy), .rd_timeout(rd_timeout)
  );

  ddr_port_arbiter #(
    .NUM_CH(N), .ADDR_W(AW), .DATA_W(DW), .CMD_W(CW),
    .RR_MODE(0), .RD_TIMEOUT(TO)
  ) dut_fp (
    .clk(clk), .rst_n(rst_n), .req(req_b), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .init_done(init_done), .cmd_busy(cmd_busy),
    .ddr_data_valid(ddr_data_valid), .ddr_rd_data(rsp_data),
    .cmd(cmd_b), .cmd_valid(cmd_valid_b),
    .ddr_address(ddr_address_b), .ddr_wr_data(ddr_wr_data_b),
    .grant(grant_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
    .busy(busy_b), .rd_timeout(rd_timeout_b)
  );

  // controller responder
  logic rsp_busy = 1'b0, rsp_valid = 1'b0;
  logic force_busy = 1'b0, stray_valid = 1'b0;
  logic auto_data = 1'b1, release_busy = 1'b0, sel = 1'b0;
  int   ph = 0, dly = 0;
  bit   rd_cmd = 1'b0;

  assign cmd_busy       = rsp_busy | force_busy;
  assign ddr_data_valid = rsp_valid | stray_valid;

  always @(negedge clk) begin
    if (!rst_n) begin
      ph = 0;
      rsp_busy = 1'b0;
      rsp_valid = 1'b0;
    end else begin
      case (ph)
        0: if (sel ? cmd_valid_b : cmd_valid) begin
          rsp_busy = 1'b1;
          rd_cmd = ((sel ? cmd_b : cmd) == CW'(CMD_READ));
          dly = $urandom_range(0, 3);
          ph = 1;
        end
        1: begin
          if (dly > 0) dly--;
          else if (!rd_cmd) begin rsp_busy = 1'b0; ph = 0; end
          else if (auto_data) begin rsp_valid = 1'b1; ph = 2; end
          else if (release_busy) begin rsp_busy = 1'b0; ph = 0; end
        end
        default: begin
          rsp_valid = 1'b0;
          rsp_busy = 1'b0;
          ph = 0;
        end
      endcase
    end
  end

  int checks = 0;
  int failures = 0;
  int mptr = N - 1;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic logic [DW-1:0] r256();
    logic [DW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic shuffle();
    for (int i = 0; i < N; i++) begin
      a_ch[i] = AW'($urandom());
      d_ch[i] = r256();
    end
    rsp_data = r256();
  endtask

  // round-robin rule: first requester after the last winner
  function automatic logic [N-1:0] model_winner(input logic [N-1:0] rv);
    logic [N-1:0] g;
    g = '0;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (mptr + 1 + k) % N;
      if (g == '0 && rv[c]) g[c] = 1'b1;
    end
    return g;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mptr = N - 1;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    while (busy && t < 40) begin @(negedge clk); t++; end
    if (busy) fail({nm, " idle"});
  endtask

  task automatic wait_grant(input string nm, input int lim, output int t);
    t = 0;
    do begin @(negedge clk); t++; end while (grant == '0 && t < lim);
    if (grant == '0) fail({nm, " grant wait"});
  endtask

  task automatic run_txn(input logic [N-1:0] rv, input logic [N-1:0] wv,
                         input logic [N-1:0] eg, input string nm);
    int w, t;
    w = 0;
    for (int i = 0; i < N; i++) if (eg[i]) w = i;
    wait_idle(nm);
    req_wr = wv;
    req = rv;
    wait_grant(nm, 20, t);
    chk({nm, " grant"}, grant, eg);
    chk({nm, " cmd"}, cmd, wv[w] ? CMD_WRITE : CMD_READ);
    chk({nm, " cmd_valid"}, cmd_valid, 1);
    chk({nm, " addr"}, ddr_address, a_ch[w]);
    if (wv[w]) chk({nm, " wdata"}, ddr_wr_data, d_ch[w]);
    req = '0;
    mptr = w;
    @(negedge clk);
    chk({nm, " grant pulse"}, grant, 0);
    if (!wv[w]) begin
      t = 0;
      do begin @(negedge clk); t++; end
      while (rd_valid == '0 && t < 20);
      chk({nm, " rd_valid"}, rd_valid, eg);
      chk({nm, " rd_data"}, rd_data, rsp_data);
      @(negedge clk);
      chk({nm, " rd_valid pulse"}, rd_valid, 0);
    end
    wait_idle(nm);
  endtask

  typedef struct packed {
    logic [N-1:0] r;
    logic [N-1:0] w;
    logic [N-1:0] g;
  } vec_t;

  vec_t tbl [9];
  logic [N-1:0] fp_exp [3];

  initial begin
    int t, n;
    logic [N-1:0] seen;
    logic [N-1:0] rv, eg;

    tbl[0] = '{5'b11111, 5'b00000, 5'b00001};
    tbl[1] = '{5'b11111, 5'b11111, 5'b00010};
    tbl[2] = '{5'b11111, 5'b00100, 5'b00100};
    tbl[3] = '{5'b11111, 5'b00000, 5'b01000};
    tbl[4] = '{5'b11111, 5'b10000, 5'b10000};
    tbl[5] = '{5'b11111, 5'b00000, 5'b00001};
    tbl[6] = '{5'b10100, 5'b00100, 5'b00100};
    tbl[7] = '{5'b00011, 5'b00000, 5'b00001};
    tbl[8] = '{5'b10000, 5'b00000, 5'b10000};
    fp_exp[0] = 5'b00010;
    fp_exp[1] = 5'b00100;
    fp_exp[2] = 5'b10000;
    shuffle();

    // reset while DDR init is pending
    req = 5'b11111;
    repeat (3) @(negedge clk);
    chk("rst busy", busy, 1);
    chk("rst grant", grant, 0);
    chk("rst ctl", {cmd_valid, rd_valid, rd_timeout, cmd}, 0);
    chk("rst addr", ddr_address, 0);
    chk("rst wdata", ddr_wr_data, 0);
    chk("rst rdata", rd_data, 0);
    rst_n = 1'b1;
    seen = '0;
    repeat (4) begin @(negedge clk); seen |= grant; end
    chk("no init busy", busy, 1);
    chk("no init grant", seen, 0);
    init_done = 1'b1;
    wait_grant("init", 4, t);
    chk("init grant", grant, 5'b00001);
    chk("init latency", t <= 2, 1);
    req = '0;
    wait_idle("init");

    do_reset();
    for (int i = 0; i < 9; i++) begin
      shuffle();
      run_txn(tbl[i].r, tbl[i].w, tbl[i].g, $sformatf("tbl%0d", i));
    end

    shuffle();
    a_ch[3] = 25'h0001200;
    rsp_data = {32{8'hA5}};
    run_txn(5'b01000, 5'b00000, 5'b01000, "ch3 read");

    // read that never returns data
    auto_data = 1'b0;
    req_wr = '0;
    req = 5'b01000;
    wait_grant("tmo", 20, t);
    req = '0;
    n = 0;
    seen = '0;
    while (!rd_timeout && n < TO + 50) begin
      @(negedge clk);
      n++;
      seen |= rd_valid;
    end
    chk("tmo flag", rd_timeout, 1);
    chk("tmo window", n >= TO && n <= TO + 4, 1);
    chk("tmo no rd_valid", seen, 0);
    repeat (3) @(negedge clk);
    chk("tmo busy held", busy, 1);
    release_busy = 1'b1;
    t = 0;
    while (busy && t < 5) begin @(negedge clk); t++; end
    chk("tmo busy clear", busy, 0);
    release_busy = 1'b0;
    auto_data = 1'b1;

    // stray data strobe in IDLE
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    seen = rd_valid;
    @(negedge clk);
    seen |= rd_valid;
    chk("stray rd_valid", seen, 0);
    chk("stray busy", busy, 0);

    // controller busy while idle blocks issue
    force_busy = 1'b1;
    req_wr = 5'b00001;
    req = 5'b00001;
    seen = '0;
    repeat (5) begin @(negedge clk); seen |= grant; end
    chk("cmd_busy block", seen, 0);
    force_busy = 1'b0;
    wait_grant("cmd_busy", 4, t);
    chk("cmd_busy grant", grant, 5'b00001);
    req = '0;
    wait_idle("cmd_busy");
    chk("tmo sticky", rd_timeout, 1);

    // init_done drop while idle
    init_done = 1'b0;
    req = 5'b00010;
    seen = '0;
    repeat (5) begin @(negedge clk); seen |= grant; end
    chk("init low block", seen, 0);
    chk("init low busy", busy, 1);
    init_done = 1'b1;
    wait_grant("init low", 4, t);
    chk("init low grant", grant, 5'b00010);
    req = '0;
    wait_idle("init low");

    // fixed-priority instance
    sel = 1'b1;
    shuffle();
    req_wr = 5'b11111;
    req_b = 5'b10110;
    seen = '0;
    for (int k = 0; k < 3; k++) begin
      int w;
      w = 0;
      for (int i = 0; i < N; i++) if (fp_exp[k][i]) w = i;
      t = 0;
      do begin @(negedge clk); t++; seen |= rd_valid_b; end
      while (grant_b == '0 && t < 20);
      chk($sformatf("fp grant%0d", k), grant_b, fp_exp[k]);
      chk($sformatf("fp cmd%0d", k), cmd_b, CMD_WRITE);
      chk($sformatf("fp addr%0d", k), ddr_address_b, a_ch[w]);
      chk($sformatf("fp wdata%0d", k), ddr_wr_data_b, d_ch[w]);
      req_b = req_b & ~fp_exp[k];
    end
    t = 0;
    while (busy_b && t < 40) begin @(negedge clk); t++; end
    chk("fp idle", busy_b, 0);
    chk("fp no rd_valid", seen, 0);
    sel = 1'b0;

    // reset in the middle of an outstanding read
    auto_data = 1'b0;
    req_wr = '0;
    req = 5'b00100;
    wait_grant("midrst", 20, t);
    req = '0;
    repeat (5) @(negedge clk);
    chk("midrst busy pre", busy, 1);
    rst_n = 1'b0;
    init_done = 1'b0;
    #1;
    chk("midrst grant", grant, 0);
    chk("midrst ctl", {cmd_valid, rd_valid, rd_timeout, cmd}, 0);
    chk("midrst addr", ddr_address, 0);
    chk("midrst rdata", rd_data, 0);
    chk("midrst busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    init_done = 1'b1;
    auto_data = 1'b1;
    mptr = N - 1;
    shuffle();
    run_txn(5'b00100, 5'b00000, 5'b00100, "post rst");

    for (int i = 0; i < 40; i++) begin
      shuffle();
      rv = N'($urandom_range(1, (1 << N) - 1));
      eg = model_winner(rv);
      run_txn(rv, N'($urandom()), eg, $sformatf("rand%0d", i));
    end

    chk("final tmo clear", rd_timeout, 0);
    chk("fp tmo", rd_timeout_b, 0);
    chk("fp rdata", rd_data_b, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

endmodule
